pll_lock_sequencer: RTL
=======================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16, giving the PLL reset hold length in clk cycles (legal range 1..65535).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096, giving the maximum cycles to wait for lock after reset release (legal range 1..65535).
REQ-003 SHALL have parameter STABLE_CYCLES, default 64, giving the consecutive synchronized lock-high cycles required before ready (legal range 1..65535).
REQ-004 SHALL have parameter MAX_RETRIES, default 3, giving the re-lock attempts allowed per enable session before fault (legal range 0..15).
REQ-005 SHALL have port: clk  input  1  PLL reference clock; all logic is on its rising edge.
REQ-006 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port: enable  input  1  synchronous request to bring the PLL up; low forces shutdown.
REQ-008 SHALL have port: pll_lock  input  1  PLL LOCK, asynchronous to clk.
REQ-009 SHALL have port: pll_resetb  output  1  drives PLL RESETB; 0 holds the PLL in reset.
REQ-010 SHALL have port: pll_bypass  output  1  drives PLL BYPASS; 1 routes the reference clock to the output.
REQ-011 SHALL have port: pll_ready  output  1  PLL output clock valid for downstream use.
REQ-012 SHALL have port: fault  output  1  retries exhausted; sticky until enable is low.
REQ-013 SHALL have port: retry_cnt  output  4  re-lock attempts used in the current session.
REQ-014 SHALL have port: state  output  3  current FSM state encoding.

Function
REQ-015 SHALL synchronize pll_lock through 2 flops to produce lock_s; all lock decisions SHALL use lock_s only.
REQ-016 SHALL implement states IDLE=0, HOLD=1, WAIT_LOCK=2, SETTLE=3, RUN=4, FAULT=5; encodings 6 and 7 SHALL go to IDLE.
REQ-017 SHALL drive all outputs from registers as functions of state: pll_resetb=1 only in WAIT_LOCK/SETTLE/RUN; pll_bypass=1 only in IDLE/FAULT; pll_ready=1 only in RUN; fault=1 only in FAULT.
REQ-018 IDLE: retry_cnt and all counters SHALL clear; enable=1 SHALL transition to HOLD.
REQ-019 HOLD: SHALL remain exactly RESET_CYCLES cycles, then transition to WAIT_LOCK with the timeout counter cleared.
REQ-020 WAIT_LOCK: lock_s=1 SHALL transition to SETTLE with the stable counter cleared; reaching LOCK_TIMEOUT cycles without lock SHALL invoke retry.
REQ-021 SETTLE: after STABLE_CYCLES consecutive lock_s=1 cycles, SHALL transition to RUN.
REQ-022 SETTLE: lock_s=0 SHALL return to WAIT_LOCK without clearing the timeout counter, so total lock wait stays bounded by LOCK_TIMEOUT.
REQ-023 RUN: lock_s=0 (loss of lock) SHALL invoke retry; pll_ready SHALL drop the cycle after lock_s=0 is sampled.
REQ-024 Retry: if retry_cnt<MAX_RETRIES, SHALL increment retry_cnt and go to HOLD; otherwise SHALL go to FAULT.
REQ-025 retry_cnt SHALL saturate and never wrap.
REQ-026 FAULT: SHALL hold until enable=0, then go to IDLE.
REQ-027 enable=0 in any state SHALL force IDLE on the next edge, with priority over every other transition.
REQ-028 When lock_s=1 and timeout expiry occur in the same WAIT_LOCK cycle, lock SHALL win.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, pll_resetb=0, pll_bypass=1, pll_ready=0, fault=0, retry_cnt=0, synchronizer flops=0, and all counters=0.
REQ-030 Release of rst_n SHALL be used synchronously; the first FSM transition SHALL occur no earlier than the first clk edge after release.

Verification
REQ-031 RESET_CYCLES=4, STABLE_CYCLES=8; enable=1 with pll_lock=1 throughout -> pll_resetb rises 4 cycles after HOLD entry, pll_ready=1 after 2 sync + 8 stable cycles, retry_cnt=0.
REQ-032 LOCK_TIMEOUT=100, MAX_RETRIES=2, pll_lock=0 throughout -> two HOLD re-entries with retry_cnt 1 then 2, then FAULT with fault=1 and pll_bypass=1; enable=0 -> IDLE with retry_cnt=0.
REQ-033 Lock toggles low once during SETTLE -> return to WAIT_LOCK, stable count restarts, retry_cnt unchanged, ready only after a full 8-cycle stable run.
REQ-034 pll_lock drops for 3 cycles in RUN -> pll_ready=0 one cycle after lock_s falls, retry_cnt=1, HOLD re-entered.
REQ-035 enable=0 asserted in the same cycle as timeout expiry -> IDLE, not HOLD; rst_n pulsed low mid-SETTLE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and the rest of the chip.
//   enable     : request to bring the PLL up (low forces shutdown)
//   pll_lock   : raw PLL LOCK, asynchronous to clk
//   pll_resetb : PLL RESETB, 0 holds the PLL in reset
//   pll_bypass : PLL BYPASS, 1 routes the reference clock to the output
//   pll_ready  : PLL output clock valid for downstream use
//   fault      : retries exhausted, sticky until enable drops
//   retry_cnt  : re-lock attempts used in the current session
//   state      : current sequencer state encoding
// slave is the sequencer side, master is the controlling side.
interface pll_lock_sequencer_if;
  logic       enable;
  logic       pll_lock;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       pll_ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  modport slave (
    input  enable, pll_lock,
    output pll_resetb, pll_bypass, pll_ready, fault, retry_cnt, state
  );

  modport master (
    output enable, pll_lock,
    input  pll_resetb, pll_bypass, pll_ready, fault, retry_cnt, state
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for a synchronized
// lock, requires a stable lock window before declaring ready, and retries a
// bounded number of times before latching a fault.
// Ports:
//   clk   : PLL reference clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pll_lock_sequencer_if.slave (enable/pll_lock in, status out)
//
// state     | meaning
// IDLE      | PLL in reset and bypassed, counters and retry count cleared
// HOLD      | PLL reset asserted for RESET_CYCLES
// WAIT_LOCK | reset released, waiting for lock within the timeout budget
// SETTLE    | lock seen, counting consecutive lock cycles
// RUN       | PLL output valid
// FAULT     | retries exhausted, bypassed until enable drops
module pll_lock_sequencer #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  pll_lock_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOLD      = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_e;

  // Down-counters are loaded with N-1 so the terminal count (0) is the Nth cycle.
  localparam logic [15:0] HOLD_LD   = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] TMO_LD    = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LD = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]  MAX_R     = 4'(MAX_RETRIES);

  logic       sync1_q, lock_s_q;
  state_e     state_q, state_d;
  logic [3:0] retry_q, retry_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic       retry_req;
  logic       resetb_q, bypass_q, ready_q, fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= bus.pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    retry_req = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      retry_d = '0;
      cnt_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          retry_d = '0;
          tmo_d   = '0;
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end
        HOLD: begin
          if (cnt_q == 16'd0) begin
            state_d = WAIT_LOCK;
            tmo_d   = TMO_LD;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        WAIT_LOCK: begin
          // Lock is checked first so it wins over a coincident timeout.
          if (lock_s_q) begin
            state_d = SETTLE;
            cnt_d   = STABLE_LD;
          end else if (tmo_q == 16'd0) begin
            retry_req = 1'b1;
          end else begin
            tmo_d = tmo_q - 16'd1;
          end
        end
        SETTLE: begin
          // Falling back keeps tmo_q, so the lock budget is shared across bounces.
          if (!lock_s_q) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == 16'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        RUN: begin
          if (!lock_s_q) retry_req = 1'b1;
        end
        FAULT: ;
        default: begin
          state_d = IDLE;
          retry_d = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      endcase
      if (retry_req) begin
        if (retry_q < MAX_R) begin
          retry_d = retry_q + 4'd1;
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          state_d = FAULT;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they change together with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      retry_q  <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      resetb_q <= 1'b0;
      bypass_q <= 1'b1;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      resetb_q <= (state_d == WAIT_LOCK) || (state_d == SETTLE) || (state_d == RUN);
      bypass_q <= (state_d == IDLE) || (state_d == FAULT);
      ready_q  <= (state_d == RUN);
      fault_q  <= (state_d == FAULT);
    end
  end

  assign bus.pll_resetb = resetb_q;
  assign bus.pll_bypass = bypass_q;
  assign bus.pll_ready  = ready_q;
  assign bus.fault      = fault_q;
  assign bus.retry_cnt  = retry_q;
  assign bus.state      = state_q;

endmodule
